// File: rtl/keypad_timer_ctrl_pkg.sv
// rtl/keypad_timer_ctrl_pkg.sv - shared types and helpers for the keypad/tick controller
package keypad_timer_ctrl_pkg;

  localparam int BCD_W     = 4;
  localparam int KEY_COUNT = 10;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESS   = 2'd1,
    ST_HELD    = 2'd2,
    ST_RELEASE = 2'd3
  } deb_state_e;

  function automatic logic key_is_single(input logic [KEY_COUNT-1:0] keys);
    return $onehot(keys);
  endfunction

  // Only meaningful when key_is_single() holds for the same vector.
  function automatic logic [BCD_W-1:0] onehot_to_bcd(input logic [KEY_COUNT-1:0] keys);
    logic [BCD_W-1:0] code;
    code = '0;
    for (int i = 0; i < KEY_COUNT; i++) begin
      if (keys[i]) code = code | BCD_W'(i);
    end
    return code;
  endfunction

endpackage

// File: rtl/keypad_timer_ctrl_debouncer.sv
// rtl/keypad_timer_ctrl_debouncer.sv - press/release debounce FSM with one-hot key encoder
module key_debouncer
  import keypad_timer_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [KEY_COUNT-1:0] keyboard,
  output logic                 accept,
  output logic [BCD_W-1:0]     code,
  output logic                 key_valid
);

  localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  deb_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d, cnt_inc;
  logic [BCD_W-1:0] code_q, code_d, key_code;
  logic             accept_q, accept_d;
  logic             key_single, key_none;

  assign key_single = key_is_single(keyboard);
  assign key_none   = (keyboard == '0);
  assign key_code   = onehot_to_bcd(keyboard);
  assign cnt_inc    = cnt_q + CNT_ONE;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    code_d   = code_q;
    accept_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (key_single) begin
          code_d = key_code;
          cnt_d  = CNT_ONE;
          if (CNT_ONE == CNT_LAST) begin
            state_d  = ST_HELD;
            accept_d = 1'b1;
          end else begin
            state_d = ST_PRESS;
          end
        end
      end
      ST_PRESS: begin
        if (key_single && key_code == code_q) begin
          cnt_d = cnt_inc;
          if (cnt_inc == CNT_LAST) begin
            state_d  = ST_HELD;
            accept_d = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      ST_HELD: begin
        if (!key_single) begin
          cnt_d   = CNT_ONE;
          state_d = (CNT_ONE == CNT_LAST) ? ST_IDLE : ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        // A fresh valid code during release is treated as the same press, never a new entry.
        if (key_single) begin
          state_d = ST_HELD;
          cnt_d   = '0;
        end else if (key_none) begin
          cnt_d = cnt_inc;
          if (cnt_inc == CNT_LAST) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      code_q   <= '0;
      accept_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      code_q   <= code_d;
      accept_q <= accept_d;
    end
  end

  assign accept    = accept_q;
  assign code      = code_q;
  assign key_valid = (state_q == ST_HELD);

endmodule

// File: rtl/keypad_timer_ctrl.sv
// rtl/keypad_timer_ctrl.sv - keypad BCD entry register, load strobe and run tick divider
module keypad_timer_ctrl
  import keypad_timer_ctrl_pkg::*;
#(
  parameter int CLK_FREQ_HZ     = 50_000_000,
  parameter int TICK_HZ         = 1,
  parameter int NUM_DIGITS      = 4,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [KEY_COUNT-1:0]          keyboard,
  input  logic                          clear_key,
  input  logic                          enablen,
  output logic [BCD_W*NUM_DIGITS-1:0]   d,
  output logic                          loadn,
  output logic                          pgt_1Hz,
  output logic                          key_valid
);

  localparam int            DW        = BCD_W * NUM_DIGITS;
  localparam int            DIV       = CLK_FREQ_HZ / TICK_HZ;
  localparam int            TW        = $clog2(DIV);
  localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);

  logic             accept;
  logic [BCD_W-1:0] code;
  logic             clr_eff;
  logic [DW-1:0]    d_q, d_d;
  logic             loadn_q, loadn_d;
  logic             clr_prev_q, clr_prev_d;
  logic [TW-1:0]    tick_cnt_q, tick_cnt_d;
  logic             tick_q, tick_d;

  key_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clk      (clk),
    .rst      (rst),
    .keyboard (keyboard),
    .accept   (accept),
    .code     (code),
    .key_valid(key_valid)
  );

  assign clr_eff = clear_key & enablen;

  // Clear beats a same-cycle accept; a held clear strobes loadn only on its first cycle.
  always_comb begin
    d_d        = d_q;
    loadn_d    = 1'b1;
    clr_prev_d = clr_eff;
    if (clr_eff) begin
      d_d     = '0;
      loadn_d = clr_prev_q;
    end else if (accept && enablen) begin
      d_d     = (d_q << BCD_W) | DW'(code);
      loadn_d = 1'b0;
    end
  end

  always_comb begin
    tick_cnt_d = '0;
    tick_d     = 1'b0;
    if (!enablen) begin
      tick_d     = (tick_cnt_q == TICK_LAST);
      tick_cnt_d = tick_d ? '0 : tick_cnt_q + TW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      d_q        <= '0;
      loadn_q    <= 1'b1;
      clr_prev_q <= 1'b0;
      tick_cnt_q <= '0;
      tick_q     <= 1'b0;
    end else begin
      d_q        <= d_d;
      loadn_q    <= loadn_d;
      clr_prev_q <= clr_prev_d;
      tick_cnt_q <= tick_cnt_d;
      tick_q     <= tick_d;
    end
  end

  assign d       = d_q;
  assign loadn   = loadn_q;
  assign pgt_1Hz = tick_q;

endmodule

// File: tb/tb_keypad_timer_ctrl.sv
// tb/tb_keypad_timer_ctrl.sv - directed self-checking bench for keypad_timer_ctrl
module tb_keypad_timer_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  keyboard;
  logic        clear_key;
  logic        enablen;
  logic [15:0] d;
  logic        loadn;
  logic        pgt_1Hz;
  logic        key_valid;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  keypad_timer_ctrl #(
    .CLK_FREQ_HZ    (10),
    .TICK_HZ        (1),
    .NUM_DIGITS     (4),
    .DEBOUNCE_CYCLES(3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .keyboard (keyboard),
    .clear_key(clear_key),
    .enablen  (enablen),
    .d        (d),
    .loadn    (loadn),
    .pgt_1Hz  (pgt_1Hz),
    .key_valid(key_valid)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n, output int lows);
    lows = 0;
    for (int i = 0; i < n; i++) begin
      step();
      if (loadn === 1'b0) lows++;
    end
  endtask

  task automatic test_reset();
    int lows;
    rst = 1'b1; keyboard = '0; clear_key = 1'b0; enablen = 1'b1;
    step(); step();
    checks++; if (d !== 16'h0000) begin errors++; $display("FAIL reset_d: got %h expected 0000", d); end
    checks++; if (loadn !== 1'b1) begin errors++; $display("FAIL reset_loadn: got %b expected 1", loadn); end
    checks++; if (pgt_1Hz !== 1'b0) begin errors++; $display("FAIL reset_pgt: got %b expected 0", pgt_1Hz); end
    checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL reset_key_valid: got %b expected 0", key_valid); end
    rst = 1'b0;
    run(3, lows);
    checks++; if (lows !== 0 || d !== 16'h0000) begin errors++; $display("FAIL idle_after_reset: lows=%0d d=%h expected 0 and 0000", lows, d); end
  endtask

  task automatic test_single_key();
    int lows;
    keyboard = 10'b0010000000;
    run(3, lows);
    checks++; if (key_valid !== 1'b1) begin errors++; $display("FAIL key7_valid: got %b expected 1", key_valid); end
    checks++; if (lows !== 0 || d !== 16'h0000) begin errors++; $display("FAIL key7_latency: lows=%0d d=%h expected 0 and 0000", lows, d); end
    step();
    checks++; if (loadn !== 1'b0 || d !== 16'h0007) begin errors++; $display("FAIL key7_load: loadn=%b d=%h expected 0 and 0007", loadn, d); end
    run(16, lows);
    checks++; if (lows !== 0) begin errors++; $display("FAIL key7_no_repeat: got %0d extra pulses expected 0", lows); end
    checks++; if (key_valid !== 1'b1) begin errors++; $display("FAIL key7_still_valid: got %b expected 1", key_valid); end
    keyboard = '0;
    run(4, lows);
    checks++; if (key_valid !== 1'b0 || d !== 16'h0007) begin errors++; $display("FAIL key7_release: key_valid=%b d=%h expected 0 and 0007", key_valid, d); end
  endtask

  task automatic test_sequence();
    int lows, total;
    total = 0;
    for (int k = 1; k <= 5; k++) begin
      keyboard = '0;
      keyboard[k] = 1'b1;
      run(4, lows); total += lows;
      keyboard = '0;
      run(4, lows); total += lows;
    end
    checks++; if (total !== 5) begin errors++; $display("FAIL seq_pulses: got %0d expected 5", total); end
    checks++; if (d !== 16'h2345) begin errors++; $display("FAIL seq_value: got %h expected 2345", d); end
  endtask

  task automatic test_glitch();
    int l0, l1, l2;
    keyboard = 10'b0000100000;
    run(2, l0);
    keyboard = 10'b0001001000;
    run(10, l1);
    checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL glitch_key_valid: got %b expected 0", key_valid); end
    keyboard = '0;
    run(4, l2);
    checks++; if (l0 + l1 + l2 !== 0) begin errors++; $display("FAIL glitch_pulses: got %0d expected 0", l0 + l1 + l2); end
    checks++; if (d !== 16'h2345) begin errors++; $display("FAIL glitch_value: got %h expected 2345", d); end
  endtask

  task automatic test_tick();
    int lows;
    logic exp;
    lows = 0;
    enablen = 1'b0;
    keyboard = 10'b1000000000;
    for (int c = 1; c <= 35; c++) begin
      step();
      if (loadn === 1'b0) lows++;
      exp = (c % 10 == 0);
      checks++; if (pgt_1Hz !== exp) begin errors++; $display("FAIL tick_c%0d: got %b expected %b", c, pgt_1Hz, exp); end
    end
    checks++; if (lows !== 0 || d !== 16'h2345) begin errors++; $display("FAIL locked_key: lows=%0d d=%h expected 0 and 2345", lows, d); end
    enablen = 1'b1;
    keyboard = '0;
    step();
    checks++; if (pgt_1Hz !== 1'b0) begin errors++; $display("FAIL tick_disabled: got %b expected 0", pgt_1Hz); end
    enablen = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      step();
      exp = (c == 10);
      checks++; if (pgt_1Hz !== exp) begin errors++; $display("FAIL tick_restart_c%0d: got %b expected %b", c, pgt_1Hz, exp); end
    end
    enablen = 1'b1;
    run(4, lows);
    checks++; if (d !== 16'h2345) begin errors++; $display("FAIL tick_end_value: got %h expected 2345", d); end
  endtask

  task automatic test_clear_same_cycle();
    int l0, l1;
    keyboard = 10'b0100000000;
    run(3, l0);
    clear_key = 1'b1;
    step();
    checks++; if (d !== 16'h0000 || loadn !== 1'b0) begin errors++; $display("FAIL clear_vs_accept: d=%h loadn=%b expected 0000 and 0", d, loadn); end
    clear_key = 1'b0;
    run(2, l1);
    checks++; if (l0 + l1 !== 0 || d !== 16'h0000) begin errors++; $display("FAIL clear_single_pulse: extra=%0d d=%h expected 0 and 0000", l0 + l1, d); end
    keyboard = '0;
    run(4, l0);
  endtask

  task automatic test_clear_held();
    int lows;
    keyboard = 10'b0001000000;
    run(4, lows);
    keyboard = '0;
    run(4, lows);
    checks++; if (d !== 16'h0006) begin errors++; $display("FAIL key6_value: got %h expected 0006", d); end
    clear_key = 1'b1;
    run(3, lows);
    checks++; if (lows !== 1 || d !== 16'h0000) begin errors++; $display("FAIL clear_held: pulses=%0d d=%h expected 1 and 0000", lows, d); end
    clear_key = 1'b0;
    step();
  endtask

  task automatic test_reset_mid_press();
    int l0, l1;
    keyboard = 10'b0000010000;
    run(2, l0);
    rst = 1'b1;
    step();
    checks++; if (loadn !== 1'b1 || key_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_press: loadn=%b key_valid=%b expected 1 and 0", loadn, key_valid); end
    rst = 1'b0;
    run(2, l0);
    keyboard = '0;
    run(4, l1);
    checks++; if (l0 + l1 !== 0 || d !== 16'h0000) begin errors++; $display("FAIL rst_no_accept: pulses=%0d d=%h expected 0 and 0000", l0 + l1, d); end
  endtask

  initial begin
    rst = 1'b1; keyboard = '0; clear_key = 1'b0; enablen = 1'b1;
    test_reset();
    test_single_key();
    test_sequence();
    test_glitch();
    test_tick();
    test_clear_same_cycle();
    test_clear_held();
    test_reset_mid_press();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
